// File: rtl/dma_bus_writer.sv
// Memory-to-bus DMA write engine: streams 512x32 buffer words onto the shared bus as arbitrated bursts.
// Bus outputs are registered; the buffer address runs one word ahead so a word can be accepted every cycle.
module dma_bus_writer (
  input  logic        clock,
  input  logic        reset,
  input  logic        startIn,
  input  logic [31:0] busStartAddressIn,
  input  logic [8:0]  memoryStartAddressIn,
  input  logic [9:0]  blockSizeIn,
  input  logic [7:0]  burstSizeIn,
  output logic [8:0]  memAddressOut,
  input  logic [31:0] memDataIn,
  output logic        busyOut,
  output logic        doneOut,
  output logic        errorOut,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  input  logic        busyIn,
  input  logic        busErrorIn,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        readNotWriteOut,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        dataValidOut
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQUEST  = 3'd1;
  localparam logic [2:0] S_INIT     = 3'd2;
  localparam logic [2:0] S_PREFETCH = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_END      = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [8:0]  mem_ptr_q, mem_ptr_d;
  logic [9:0]  remain_q, remain_d;
  logic [7:0]  burst_cfg_q, burst_cfg_d;
  logic [7:0]  burst_last_q, burst_last_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        req_q, req_d;
  logic [31:0] ad_q, ad_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  bsize_q, bsize_d;
  logic        begin_q, begin_d;
  logic        end_q, end_d;
  logic        dv_q, dv_d;

  logic [9:0]  remain_m1;
  logic [7:0]  next_burst_last;
  logic        last_word;
  logic        accept;

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Burst length minus one: min(burstSize, remaining-1), remaining is never 0 here
  assign remain_m1       = remain_q - 10'd1;
  assign next_burst_last = (remain_m1 < {2'b00, burst_cfg_q}) ? remain_m1[7:0] : burst_cfg_q;
  assign last_word       = (burst_cnt_q == burst_last_q);
  assign accept          = (state_q == S_WRITE) && !busyIn && !busErrorIn;

  // mem_ptr_q addresses the word to load on the next acceptance; jump ahead while accepting
  assign memAddressOut = (accept && !last_word) ? mem_ptr_q + 9'd1 : mem_ptr_q;

  always_comb begin
    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    mem_ptr_d    = mem_ptr_q;
    remain_d     = remain_q;
    burst_cfg_d  = burst_cfg_q;
    burst_last_d = burst_last_q;
    burst_cnt_d  = burst_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    req_d        = 1'b0;
    ad_d         = 32'd0;
    be_d         = 4'h0;
    bsize_d      = 8'd0;
    begin_d      = 1'b0;
    end_d        = 1'b0;
    dv_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (startIn) begin
          if (blockSizeIn == 10'd0) begin
            done_d = 1'b1;
          end else begin
            bus_addr_d  = busStartAddressIn;
            mem_ptr_d   = memoryStartAddressIn;
            remain_d    = blockSizeIn;
            burst_cfg_d = burstSizeIn;
            error_d     = 1'b0;
            busy_d      = 1'b1;
            req_d       = 1'b1;
            state_d     = S_REQUEST;
          end
        end
      end
      S_REQUEST: begin
        req_d = 1'b1;
        if (transactionGranted) state_d = S_INIT;
      end
      S_INIT: begin
        if (busErrorIn) begin
          end_d   = 1'b1;
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          req_d        = 1'b1;
          begin_d      = 1'b1;
          ad_d         = bus_addr_q;
          be_d         = 4'hF;
          bsize_d      = next_burst_last;
          burst_last_d = next_burst_last;
          burst_cnt_d  = 8'd0;
          mem_ptr_d    = mem_ptr_q + 9'd1;
          state_d      = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        if (busErrorIn) begin
          end_d   = 1'b1;
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          req_d   = 1'b1;
          dv_d    = 1'b1;
          be_d    = 4'hF;
          ad_d    = byte_swap(memDataIn);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (busErrorIn) begin
          end_d   = 1'b1;
          error_d = 1'b1;
          state_d = S_ERROR;
        end else if (busyIn) begin
          req_d = 1'b1;
          dv_d  = 1'b1;
          be_d  = 4'hF;
          ad_d  = ad_q;
        end else begin
          bus_addr_d = bus_addr_q + 32'd4;
          remain_d   = remain_m1;
          if (last_word) begin
            end_d   = 1'b1;
            state_d = S_END;
          end else begin
            req_d       = 1'b1;
            dv_d        = 1'b1;
            be_d        = 4'hF;
            ad_d        = byte_swap(memDataIn);
            burst_cnt_d = burst_cnt_q + 8'd1;
            mem_ptr_d   = mem_ptr_q + 9'd1;
          end
        end
      end
      S_END: begin
        if (remain_q != 10'd0) begin
          req_d   = 1'b1;
          state_d = S_REQUEST;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bus_addr_q   <= 32'd0;
      mem_ptr_q    <= 9'd0;
      remain_q     <= 10'd0;
      burst_cfg_q  <= 8'd0;
      burst_last_q <= 8'd0;
      burst_cnt_q  <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      req_q        <= 1'b0;
      ad_q         <= 32'd0;
      be_q         <= 4'h0;
      bsize_q      <= 8'd0;
      begin_q      <= 1'b0;
      end_q        <= 1'b0;
      dv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_addr_q   <= bus_addr_d;
      mem_ptr_q    <= mem_ptr_d;
      remain_q     <= remain_d;
      burst_cfg_q  <= burst_cfg_d;
      burst_last_q <= burst_last_d;
      burst_cnt_q  <= burst_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      req_q        <= req_d;
      ad_q         <= ad_d;
      be_q         <= be_d;
      bsize_q      <= bsize_d;
      begin_q      <= begin_d;
      end_q        <= end_d;
      dv_q         <= dv_d;
    end
  end

  assign busyOut             = busy_q;
  assign doneOut             = done_q;
  assign errorOut            = error_q;
  assign requestTransaction  = req_q;
  assign addressDataOut      = ad_q;
  assign byteEnablesOut      = be_q;
  assign burstSizeOut        = bsize_q;
  assign readNotWriteOut     = 1'b0;
  assign beginTransactionOut = begin_q;
  assign endTransactionOut   = end_q;
  assign dataValidOut        = dv_q;

endmodule

// File: tb/tb_dma_bus_writer.sv
// Bench for dma_bus_writer: table of transfers plus randomized transfers, each checked against a burst-level model.
module tb_dma_bus_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        startIn = 1'b0;
  logic [31:0] busStartAddressIn = 32'd0;
  logic [8:0]  memoryStartAddressIn = 9'd0;
  logic [9:0]  blockSizeIn = 10'd0;
  logic [7:0]  burstSizeIn = 8'd0;
  logic [8:0]  memAddressOut;
  logic [31:0] memDataIn = 32'd0;
  logic        busyOut, doneOut, errorOut, requestTransaction;
  logic        transactionGranted = 1'b0;
  logic        busyIn = 1'b0;
  logic        busErrorIn = 1'b0;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut;

  dma_bus_writer dut (
    .clock(clock), .reset(reset), .startIn(startIn),
    .busStartAddressIn(busStartAddressIn), .memoryStartAddressIn(memoryStartAddressIn),
    .blockSizeIn(blockSizeIn), .burstSizeIn(burstSizeIn),
    .memAddressOut(memAddressOut), .memDataIn(memDataIn),
    .busyOut(busyOut), .doneOut(doneOut), .errorOut(errorOut),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
    .busyIn(busyIn), .busErrorIn(busErrorIn),
    .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
    .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
    .dataValidOut(dataValidOut)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [31:0] bus;
    logic [8:0]  mem;
    logic [9:0]  blk;
    logic [7:0]  bsz;
    int          stall;
    int          exp_bursts;
    logic [7:0]  exp_last_bsz;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] bufm[512];
  int          checks = 0;
  int          errors = 0;

  // Slave/arbiter knobs and observations
  int          stall_mode = 0;
  int          gnt_rand = 0;
  int          err_word = -1;
  bit          err_done = 0;
  int          dcyc = 0, acc = 0, req_rises = 0, ends = 0, dones = 0;
  bit          prev_req = 0, busy_seen = 0;
  logic [31:0] obs_words[$];
  logic [31:0] obs_baddr[$];
  logic [7:0]  obs_bsz[$];
  logic [8:0]  mseq[$];

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [63:0] outs();
    return {3'b000, busyOut, doneOut, errorOut, requestTransaction, beginTransactionOut,
            endTransactionOut, dataValidOut, readNotWriteOut, byteEnablesOut, burstSizeOut,
            memAddressOut, addressDataOut};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous buffer: data follows the address by one cycle
  initial forever @(posedge clock) memDataIn <= bufm[memAddressOut];

  initial forever begin
    @(negedge clock);
    #2;
    if (busyOut && (mseq.size() == 0 || mseq[mseq.size()-1] != memAddressOut))
      mseq.push_back(memAddressOut);
  end

  initial forever begin
    @(negedge clock);
    transactionGranted = requestTransaction && (gnt_rand == 0 || $urandom_range(0, 2) != 0);
    busyIn = 1'b0;
    busErrorIn = 1'b0;
    if (dataValidOut) begin
      dcyc++;
      if (stall_mode == 1) busyIn = (dcyc == 2 || dcyc == 3);
      else if (stall_mode == 2) busyIn = ($urandom_range(0, 3) == 0);
      if (err_word >= 0 && !err_done && acc == err_word) begin
        busyIn = 1'b0;
        busErrorIn = 1'b1;
        err_done = 1;
      end
      if (!busyIn && !busErrorIn) begin
        obs_words.push_back(addressDataOut);
        acc++;
      end
    end
    if (beginTransactionOut) begin
      obs_baddr.push_back(addressDataOut);
      obs_bsz.push_back(burstSizeOut);
    end
    if (endTransactionOut) ends++;
    if (doneOut) dones++;
    if (requestTransaction && !prev_req) req_rises++;
    prev_req = requestTransaction;
    if (busyOut) busy_seen = 1;
  end

  task automatic run_xfer(input logic [31:0] ba, input logic [8:0] ma, input logic [9:0] bl,
                          input logic [7:0] bs, input int sm, input int gr, input int ew);
    bit got;
    @(negedge clock);
    stall_mode = sm; gnt_rand = gr; err_word = ew; err_done = 0;
    dcyc = 0; acc = 0; req_rises = 0; ends = 0; dones = 0; busy_seen = 0;
    obs_words.delete(); obs_baddr.delete(); obs_bsz.delete(); mseq.delete();
    busStartAddressIn = ba; memoryStartAddressIn = ma; blockSizeIn = bl; burstSizeIn = bs;
    startIn = 1'b1;
    @(negedge clock);
    startIn = 1'b0;
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      if (doneOut) begin
        got = 1;
        break;
      end
      @(negedge clock);
      // A start pulse while busy must be ignored
      if (c == 1 && bl != 10'd0) begin
        startIn = 1'b1; busStartAddressIn = 32'hDEAD_BEE0; memoryStartAddressIn = 9'd77;
        blockSizeIn = 10'd3; burstSizeIn = 8'd0;
      end else begin
        startIn = 1'b0;
      end
    end
    startIn = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic verify(input logic [31:0] ba, input logic [8:0] ma, input logic [9:0] bl,
                        input logic [7:0] bs);
    logic [31:0] e_addr[$];
    logic [7:0]  e_bsz[$];
    logic [31:0] e_words[$];
    int          rem = int'(bl);
    int          m = int'(ma);
    int          len;
    logic [31:0] a = ba;
    while (rem > 0) begin
      len = (int'(bs) + 1 < rem) ? int'(bs) + 1 : rem;
      e_addr.push_back(a);
      e_bsz.push_back(8'(len - 1));
      for (int i = 0; i < len; i++) begin
        e_words.push_back(swap32(bufm[m]));
        m = (m + 1) % 512;
        a = a + 32'd4;
      end
      rem -= len;
    end
    chk("burst_count", 64'(obs_baddr.size()), 64'(e_addr.size()));
    for (int i = 0; i < obs_baddr.size() && i < e_addr.size(); i++) begin
      chk($sformatf("burst%0d_addr", i), 64'(obs_baddr[i]), 64'(e_addr[i]));
      chk($sformatf("burst%0d_size", i), 64'(obs_bsz[i]), 64'(e_bsz[i]));
    end
    chk("word_count", 64'(obs_words.size()), 64'(e_words.size()));
    for (int i = 0; i < obs_words.size() && i < e_words.size(); i++)
      chk($sformatf("word%0d", i), 64'(obs_words[i]), 64'(e_words[i]));
    chk("requests", 64'(req_rises), 64'(e_addr.size()));
    chk("end_pulses", 64'(ends), 64'(e_addr.size()));
    chk("done_pulses", 64'(dones), 64'd1);
    chk("error_flag", 64'(errorOut), 64'd0);
    chk("busy_after", 64'(busyOut), 64'd0);
  endtask

  initial begin
    logic [35:0] seq4;
    logic [31:0] ba;
    logic [8:0]  ma;
    logic [9:0]  bl;
    logic [7:0]  bs;
    bit          got;

    vecs[0] = '{32'h0000_1000, 9'd0,   10'd4,   8'd3,   0, 1, 8'd3,  32'h0000_1000};
    vecs[1] = '{32'h0000_1000, 9'd0,   10'd10,  8'd3,   0, 3, 8'd1,  32'h0000_1020};
    vecs[2] = '{32'h0000_1000, 9'd0,   10'd4,   8'd3,   1, 1, 8'd3,  32'h0000_1000};
    vecs[3] = '{32'h0000_2000, 9'd510, 10'd4,   8'd7,   0, 1, 8'd3,  32'h0000_2000};
    vecs[4] = '{32'hFFFF_FFF8, 9'd5,   10'd5,   8'd1,   0, 3, 8'd0,  32'h0000_0008};
    vecs[5] = '{32'h0000_0100, 9'd100, 10'd1,   8'd0,   0, 1, 8'd0,  32'h0000_0100};
    vecs[6] = '{32'h0000_0000, 9'd0,   10'd300, 8'd255, 0, 2, 8'd43, 32'h0000_0400};
    vecs[7] = '{32'h0000_0040, 9'd0,   10'd7,   8'd255, 0, 1, 8'd6,  32'h0000_0040};

    for (int i = 0; i < 512; i++) bufm[i] = $urandom;
    bufm[0] = 32'h1122_3344;

    repeat (3) @(negedge clock);
    chk("reset_outputs", outs(), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_outputs", outs(), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i].bus, vecs[i].mem, vecs[i].blk, vecs[i].bsz, vecs[i].stall, 0, -1);
      verify(vecs[i].bus, vecs[i].mem, vecs[i].blk, vecs[i].bsz);
      chk($sformatf("tbl%0d_bursts", i), 64'(obs_baddr.size()), 64'(vecs[i].exp_bursts));
      chk($sformatf("tbl%0d_last_bsz", i),
          64'(obs_bsz.size() > 0 ? obs_bsz[obs_bsz.size()-1] : 8'hxx), 64'(vecs[i].exp_last_bsz));
      chk($sformatf("tbl%0d_last_addr", i),
          64'(obs_baddr.size() > 0 ? obs_baddr[obs_baddr.size()-1] : 32'hxxxx_xxxx),
          64'(vecs[i].exp_last_addr));
      if (i == 0)
        chk("first_word_swapped", 64'(obs_words.size() > 0 ? obs_words[0] : 32'hxxxx_xxxx),
            64'h4433_2211);
      if (i == 2) chk("stall_data_cycles", 64'(dcyc), 64'd6);
      if (i == 3) begin
        seq4 = '1;
        if (mseq.size() >= 4) seq4 = {mseq[0], mseq[1], mseq[2], mseq[3]};
        chk("mem_addr_wrap_seq", 64'(seq4), 64'({9'd510, 9'd511, 9'd0, 9'd1}));
      end
    end

    // Bus error on the second word aborts the block
    run_xfer(32'h0000_3000, 9'd20, 10'd8, 8'd7, 0, 0, 1);
    chk("err_words", 64'(obs_words.size()), 64'd1);
    chk("err_first_word", 64'(obs_words.size() > 0 ? obs_words[0] : 32'hxxxx_xxxx),
        64'(swap32(bufm[20])));
    chk("err_end_pulses", 64'(ends), 64'd1);
    chk("err_done_pulses", 64'(dones), 64'd1);
    chk("err_flag_set", 64'(errorOut), 64'd1);
    chk("err_busy_after", 64'(busyOut), 64'd0);
    run_xfer(32'h0000_4000, 9'd40, 10'd6, 8'd3, 0, 0, -1);
    verify(32'h0000_4000, 9'd40, 10'd6, 8'd3);

    // Reset in the middle of a data phase
    @(negedge clock);
    stall_mode = 0; gnt_rand = 0; err_word = -1;
    busStartAddressIn = 32'h0000_5000; memoryStartAddressIn = 9'd0;
    blockSizeIn = 10'd20; burstSizeIn = 8'd15;
    startIn = 1'b1;
    @(negedge clock);
    startIn = 1'b0;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      if (dataValidOut) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    chk("reached_write", 64'(got), 64'd1);
    #2 reset = 1'b0;
    #1 chk("reset_mid_write", outs(), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    run_xfer(32'h0000_6000, 9'd0, 10'd0, 8'd3, 0, 0, -1);
    chk("zero_blk_done", 64'(dones), 64'd1);
    chk("zero_blk_requests", 64'(req_rises), 64'd0);
    chk("zero_blk_busy", 64'(busy_seen), 64'd0);

    for (int r = 0; r < 24; r++) begin
      ba = $urandom & 32'hFFFF_FFFC;
      ma = 9'($urandom_range(0, 511));
      bl = 10'($urandom_range(1, 64));
      bs = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      run_xfer(ba, ma, bl, bs, 2, 1, -1);
      verify(ba, ma, bl, bs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_bus_writer.md
Name: dma_bus_writer

Overview:
- Memory-to-bus DMA write engine: the outbound counterpart of the DMA read engine.
- Fetches words from the 512x32 DMA buffer through a dedicated synchronous read port and writes them to the shared bus as arbitrated bursts.
- Configuration comes from the DMA custom-instruction register file: bus start address, memory start address, block size and burst size, plus a one-cycle start pulse.
- Reports busy, done and a sticky error.

Parameters:
- none (the buffer is fixed at 512 words; addresses are 9 bits)

Ports:
- clock  in  1  system clock; everything updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- startIn  in  1  one-cycle start pulse; ignored while busyOut=1
- busStartAddressIn  in  32  first bus byte address; word aligned
- memoryStartAddressIn  in  9  first buffer word address
- blockSizeIn  in  10  total number of words to transfer
- burstSizeIn  in  8  burst length minus 1 (value 7 means 8 words)
- memAddressOut  out  9  buffer read address
- memDataIn  in  32  buffer read data, valid one cycle after memAddressOut
- busyOut  out  1  transfer in progress
- doneOut  out  1  one-cycle pulse on completion or error exit
- errorOut  out  1  sticky bus-error flag; cleared by the next accepted start
- requestTransaction  out  1  bus request to the arbiter
- transactionGranted  in  1  grant from the arbiter
- busyIn  in  1  slave wait; the current data word is held while high
- busErrorIn  in  1  slave error
- addressDataOut  out  32  address during the begin cycle, byte-swapped data during data cycles
- byteEnablesOut  out  4  4'hF during begin and data cycles, else 0
- burstSizeOut  out  8  current burst length minus 1, begin cycle only
- readNotWriteOut  out  1  always 0 (write only)
- beginTransactionOut  out  1
- endTransactionOut  out  1
- dataValidOut  out  1

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; counters 0; errorOut 0.
- All bus outputs are registered.
- States: IDLE, REQUEST, INIT_BURST, PREFETCH, WRITE, END_BURST, ERROR.
- IDLE:
  - startIn with blockSizeIn=0: no bus activity, doneOut pulses the next cycle, busyOut stays 0.
  - startIn with blockSizeIn>0: latch the configuration, clear errorOut, set remaining=blockSizeIn, set busyOut, go to REQUEST.
- REQUEST: requestTransaction=1; remain here until transactionGranted=1, then go to INIT_BURST.
- INIT_BURST:
  - Burst length L = min(burstSize+1, remaining).
  - Next cycle: beginTransactionOut=1, addressDataOut=current bus address, burstSizeOut=L-1, byteEnablesOut=F.
  - memAddressOut = current memory address.
  - Go to PREFETCH.
- PREFETCH: one cycle so memDataIn is valid; go to WRITE.
- WRITE:
  - dataValidOut=1.
  - addressDataOut = {d[7:0], d[15:8], d[23:16], d[31:24]} (big-endian bus).
  - A word is accepted on a cycle with dataValidOut=1 and busyIn=0. On acceptance: memory address +1 (wraps 511->0), bus address +4, remaining -1, burst count +1.
  - The next word must be presented the following cycle: look-ahead read of the buffer.
  - While busyIn=1 the word and dataValidOut are held unchanged.
  - After the L-th word is accepted: go to END_BURST.
- END_BURST:
  - endTransactionOut=1 for one cycle; dataValidOut=0; request dropped.
  - If remaining>0: go to REQUEST (re-arbitrate every burst).
  - Else: go to IDLE, clear busyOut, pulse doneOut.
- busErrorIn=1 in any state from INIT_BURST through WRITE:
  - dataValidOut drops next cycle; endTransactionOut pulses once; errorOut set.
  - Go to ERROR; one cycle later go to IDLE with a doneOut pulse.
- busErrorIn in REQUEST or IDLE is ignored.
- Bus address arithmetic is 32-bit and wraps modulo 2^32. The remaining count never underflows.
- startIn while busy: ignored, the configuration is unchanged.
- Reset mid-burst: outputs drop immediately; no endTransactionOut is issued.

Test Plan:
- Start: bus 0x1000, mem 0, block 4, burst 3, slave never busy; buffer holds 0x11223344 at word 0 -> one burst: begin with address 0x1000, burstSizeOut 3, four data cycles (first = 0x44332211), endTransactionOut, doneOut; 1 request total.
- Block 10, burst 3 -> bursts of 4, 4 and 2 words; burstSizeOut values 3, 3, 1; bus addresses 0x1000, 0x1010, 0x1020; requestTransaction asserted 3 times.
- Slave asserts busyIn on the 2nd and 3rd data cycles -> word 2 is held for 3 cycles; no word is lost or duplicated.
- busErrorIn on the 2nd word of block 8 -> endTransactionOut pulse, errorOut=1, doneOut pulse, IDLE; the next start clears errorOut.
- Memory start 510, block 4 -> memAddressOut sequence 510, 511, 0, 1.
- reset=0 asserted mid-WRITE -> all outputs 0 in the same cycle; startIn with blockSizeIn=0 -> doneOut only, no request.
